// File: rtl/probe_bank_core.sv
// probe_bank_core: bus-mapped bank of NUM_IN input probes and NUM_OUT output
// probes on the 16-bit host bus, with capture control, a wrapping 16-bit
// capture counter and optional sticky per-channel change flags.
// Optional feature macro: PROBE_CHANGE_FLAGS_EN builds the CHG register at
// offset 2; without it offset 2 reads 0 and writes to it are ignored.
// Bus transactions pass through with one cycle of latency; in-range valid
// reads have their data replaced by the addressed register value.

module probe_bank_core #(
    parameter logic [15:0] BASE_ADDR = 16'd0,
    parameter int          NUM_IN    = 4,
    parameter int          IN_WIDTH  = 32,
    parameter int          NUM_OUT   = 2,
    parameter int          OUT_WIDTH = 16,
    localparam int         OUT_BITS  = (NUM_OUT > 0) ? NUM_OUT * OUT_WIDTH : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN*IN_WIDTH-1:0] probes_in,
    output logic [OUT_BITS-1:0]        probes_out,
    input  logic [15:0]                addr_i,
    input  logic [15:0]                data_i,
    input  logic                       rw_i,
    input  logic                       valid_i,
    output logic [15:0]                addr_o,
    output logic [15:0]                data_o,
    output logic                       rw_o,
    output logic                       valid_o
);

    localparam int IN_BITS   = NUM_IN * IN_WIDTH;
    localparam int WPC       = (IN_WIDTH + 15) / 16;     // bus words per input channel
    localparam int PAD_WIDTH = WPC * 16;                 // channel width rounded up to words
    localparam int IN_START  = 3;
    localparam int OUT_START = IN_START + NUM_IN * WPC;
    localparam int SPAN      = OUT_START + NUM_OUT;

    localparam logic [15:0] OFF_CTRL   = 16'd0;
    localparam logic [15:0] OFF_CAPCNT = 16'd1;
    localparam logic [15:0] OFF_CHG    = 16'd2;

    // Address decode
    logic [16:0] addr_diff;
    logic [15:0] off;
    logic        hit;
    logic        rd_hit;
    logic        wr_hit;
    logic        ctrl_wr;
    logic        cap;

    // Registered state
    logic                 strobe_q, strobe_d;
    logic                 pulse_pending_q, pulse_pending_d;
    logic [15:0]          capcnt_q, capcnt_d;
    logic [IN_BITS-1:0]   in_buf_q, in_buf_d;
    logic [OUT_BITS-1:0]  out_buf_q, out_buf_d;
    logic [OUT_BITS-1:0]  probes_out_q, probes_out_d;
    logic [15:0]          addr_q, addr_d;
    logic [15:0]          data_q, data_d;
    logic                 rw_q, rw_d;
    logic                 valid_q, valid_d;

    // Read path helpers
    logic [NUM_IN*PAD_WIDTH-1:0] in_pad;
    logic [15:0]                 rdata;

    // A 17-bit difference lets addresses below BASE_ADDR fall out of range cleanly.
    assign addr_diff = {1'b0, addr_i} - {1'b0, BASE_ADDR};
    assign off       = addr_diff[15:0];
    assign hit       = valid_i && !addr_diff[16] && (off < 16'(SPAN));
    assign rd_hit    = hit && !rw_i;
    assign wr_hit    = hit && rw_i;
    assign ctrl_wr   = wr_hit && (off == OFF_CTRL);
    assign cap       = strobe_q || pulse_pending_q;

    // CTRL: STROBE is a level; PULSE arms exactly one capture on the next edge.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        strobe_d = strobe_q;
        if (ctrl_wr) begin
            strobe_d = data_i[0];
        end
        // A pending pulse always captures on the following edge, so it only
        // ever lives for one cycle and never needs to be held.
        pulse_pending_d = ctrl_wr && data_i[1];
    end

    // Capture datapath and output-buffer writes; a same-edge write is seen by
    // probes_out only on the next capture because the capture copies out_buf_q.
    always_comb begin
        in_buf_d     = in_buf_q;
        out_buf_d    = out_buf_q;
        probes_out_d = probes_out_q;
        capcnt_d     = capcnt_q;
        if (cap) begin
            in_buf_d     = probes_in;
            probes_out_d = out_buf_q;
            capcnt_d     = capcnt_q + 16'd1;
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (wr_hit && (off == 16'(OUT_START + j))) begin
                out_buf_d[j*OUT_WIDTH +: OUT_WIDTH] = data_i[OUT_WIDTH-1:0];
            end
        end
    end

`ifdef PROBE_CHANGE_FLAGS_EN
    logic [NUM_IN-1:0] chg_q, chg_d, chg_set;

    // Sticky change flags: W1C first, then capture sets so a same-edge set wins.
    always_comb begin
        chg_set = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            chg_set[i] = probes_in[i*IN_WIDTH +: IN_WIDTH] != in_buf_q[i*IN_WIDTH +: IN_WIDTH];
        end
        chg_d = chg_q;
        if (wr_hit && (off == OFF_CHG)) begin
            chg_d = chg_d & ~data_i[NUM_IN-1:0];
        end
        if (cap) begin
            chg_d = chg_d | chg_set;
        end
    end

    // Change flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q <= '0;
        end else begin
            chg_q <= chg_d;
        end
    end
`endif

    // Zero-extend each input channel to a whole number of bus words.
    always_comb begin
        in_pad = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_pad[i*PAD_WIDTH +: IN_WIDTH] = in_buf_q[i*IN_WIDTH +: IN_WIDTH];
        end
    end

    // Register read mux; reflects state before the edge that returns it.
    always_comb begin
        rdata = '0;
        if (off == OFF_CTRL) begin
            rdata[0] = strobe_q;
        end
        if (off == OFF_CAPCNT) begin
            rdata = capcnt_q;
        end
`ifdef PROBE_CHANGE_FLAGS_EN
        if (off == OFF_CHG) begin
            rdata[NUM_IN-1:0] = chg_q;
        end
`endif
        for (int k = 0; k < NUM_IN * WPC; k++) begin
            if (off == 16'(IN_START + k)) begin
                rdata = in_pad[k*16 +: 16];
            end
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (off == 16'(OUT_START + j)) begin
                rdata[OUT_WIDTH-1:0] = out_buf_q[j*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    // Bus pass-through; only in-range valid reads have their data replaced.
    always_comb begin
        addr_d  = addr_i;
        data_d  = rd_hit ? rdata : data_i;
        rw_d    = rw_i;
        valid_d = valid_i;
    end

    // State register for control, buffers, counter and bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the probe buffers are cleared too, since they are observable on the bus and probes_out right after reset.
            strobe_q        <= 1'b0;
            pulse_pending_q <= 1'b0;
            capcnt_q        <= '0;
            in_buf_q        <= '0;
            out_buf_q       <= '0;
            probes_out_q    <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            rw_q            <= 1'b0;
            valid_q         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            strobe_q        <= strobe_d;
            pulse_pending_q <= pulse_pending_d;
            capcnt_q        <= capcnt_d;
            in_buf_q        <= in_buf_d;
            out_buf_q       <= out_buf_d;
            probes_out_q    <= probes_out_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            rw_q            <= rw_d;
            valid_q         <= valid_d;
        end
    end

    assign probes_out = probes_out_q;
    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign rw_o       = rw_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_probe_bank_core.sv
// Testbench for probe_bank_core: directed scenarios plus a randomized
// back-to-back run, all compared against a behavioural model of the register
// map kept in this file. Honours PROBE_CHANGE_FLAGS_EN when it is defined.
`timescale 1ns/1ps

module tb_probe_bank_core;

    localparam logic [15:0] BASE = 16'h0040;
    localparam int NI        = 2;
    localparam int IW        = 20;
    localparam int W         = 2;
    localparam int NO        = 2;
    localparam int OW        = 8;
    localparam int PW        = NI * IW;
    localparam int OUT_START = 3 + NI * W;
    localparam int SPAN      = OUT_START + NO;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [PW-1:0]  probes_in = '0;
    logic [NO*OW-1:0] probes_out;
    logic [15:0]    addr_i = '0;
    logic [15:0]    data_i = '0;
    logic           rw_i = 1'b0;
    logic           valid_i = 1'b0;
    logic [15:0]    addr_o;
    logic [15:0]    data_o;
    logic           rw_o;
    logic           valid_o;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [IW-1:0]  m_in [NI];
    logic [OW-1:0]  m_out [NO];
    logic [OW-1:0]  m_pout [NO];
    logic           m_strobe;
    logic           m_pend;
    logic [15:0]    m_cnt;
    logic [NI-1:0]  m_chg;
    logic [15:0]    exp_addr;
    logic [15:0]    exp_data;
    logic           exp_rw;
    logic           exp_valid;

    probe_bank_core #(
        .BASE_ADDR (BASE),
        .NUM_IN    (NI),
        .IN_WIDTH  (IW),
        .NUM_OUT   (NO),
        .OUT_WIDTH (OW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .probes_in  (probes_in),
        .probes_out (probes_out),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .addr_o     (addr_o),
        .data_o     (data_o),
        .rw_o       (rw_o),
        .valid_o    (valid_o)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < NI; i++) m_in[i] = '0;
        for (int j = 0; j < NO; j++) begin
            m_out[j]  = '0;
            m_pout[j] = '0;
        end
        m_strobe = 1'b0;
        m_pend   = 1'b0;
        m_cnt    = '0;
        m_chg    = '0;
    endtask

    function automatic logic [15:0] model_rd(input int off);
        logic [15:0] v;
        logic [31:0] wide;
        int k;
        v = '0;
        if (off == 0) begin
            v = {15'd0, m_strobe};
        end else if (off == 1) begin
            v = m_cnt;
        end else if (off == 2) begin
`ifdef PROBE_CHANGE_FLAGS_EN
            v = 16'(m_chg);
`endif
        end else if (off < OUT_START) begin
            k    = off - 3;
            wide = 32'(m_in[k / W]);
            v    = 16'(wide >> (16 * (k % W)));
        end else begin
            v = 16'(m_out[off - OUT_START]);
        end
        return v;
    endfunction

    function automatic logic [NO*OW-1:0] model_pout();
        logic [NO*OW-1:0] v;
        for (int j = 0; j < NO; j++) v[j*OW +: OW] = m_pout[j];
        return v;
    endfunction

    // Applies one clock edge of the register-map rules to the model.
    task automatic model_edge();
        logic          capture;
        logic          pulse_req;
        logic [NI-1:0] set_mask;
        logic [NI-1:0] clr_mask;
        logic [IW-1:0] cur;
        int            off;
        logic          in_map;
        off      = int'(addr_i) - int'(BASE);
        in_map   = (off >= 0) && (off < SPAN);
        capture  = m_strobe | m_pend;
        exp_addr  = addr_i;
        exp_rw    = rw_i;
        exp_valid = valid_i;
        exp_data  = (valid_i && !rw_i && in_map) ? model_rd(off) : data_i;
        set_mask  = '0;
        clr_mask  = '0;
        pulse_req = 1'b0;
        if (capture) begin
            for (int i = 0; i < NI; i++) begin
                cur = probes_in[i*IW +: IW];
                if (cur != m_in[i]) set_mask[i] = 1'b1;
                m_in[i] = cur;
            end
            for (int j = 0; j < NO; j++) m_pout[j] = m_out[j];
            m_cnt = m_cnt + 16'd1;
        end
        if (valid_i && rw_i && in_map) begin
            if (off == 0) begin
                m_strobe  = data_i[0];
                pulse_req = data_i[1];
            end
            if (off == 2) clr_mask = data_i[NI-1:0];
            if (off >= OUT_START) m_out[off - OUT_START] = data_i[OW-1:0];
        end
        m_pend = pulse_req | (m_pend & ~capture);
`ifdef PROBE_CHANGE_FLAGS_EN
        m_chg = (m_chg & ~clr_mask) | set_mask;
`endif
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic rw, input logic [15:0] a, input logic [15:0] d);
        valid_i = v;
        rw_i    = rw;
        addr_i  = a;
        data_i  = d;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic wr(input int off, input logic [15:0] d);
        drive(1'b1, 1'b1, 16'(int'(BASE) + off), d);
    endtask

    task automatic rd(input int off);
        drive(1'b1, 1'b0, 16'(int'(BASE) + off), 16'($urandom()));
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 1'($urandom()), 16'($urandom()), 16'($urandom()));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            probes_in = PW'({$urandom(), $urandom()});
            valid_i   = 1'b1;
            rw_i      = 1'($urandom());
            addr_i    = BASE + 16'($urandom_range(0, SPAN - 1));
            data_i    = 16'($urandom());
            @(posedge clk);
            #1;
        end
        checks++; if (addr_o !== 16'h0) begin errors++; $display("FAIL reset_addr_o: got %h want 0000", addr_o); end
        checks++; if (data_o !== 16'h0) begin errors++; $display("FAIL reset_data_o: got %h want 0000", data_o); end
        checks++; if (rw_o !== 1'b0) begin errors++; $display("FAIL reset_rw_o: got %b want 0", rw_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %b want 0", valid_o); end
        checks++; if (probes_out !== '0) begin errors++; $display("FAIL reset_probes_out: got %h want 0", probes_out); end
        rst_n = 1'b1;
        model_reset();
        idle(2);
        checks++; if (probes_out !== '0) begin errors++; $display("FAIL idle_probes_out: got %h want 0", probes_out); end
        for (int off = 0; off < 3; off++) begin
            rd(off);
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL idle_rd%0d_valid: got %b want 1", off, valid_o); end
            checks++; if (data_o !== 16'h0000) begin errors++; $display("FAIL idle_rd%0d_data: got %h want 0000", off, data_o); end
        end
        // Reset asserted mid-transaction clears the outputs at once and drops the request.
        valid_i = 1'b1;
        rw_i    = 1'b0;
        addr_i  = BASE;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b want 0", valid_o); end
        checks++; if (addr_o !== 16'h0) begin errors++; $display("FAIL async_reset_addr: got %h want 0000", addr_o); end
        @(posedge clk);
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL dropped_txn_valid: got %b want 0", valid_o); end
        rst_n = 1'b1;
        model_reset();
        idle(1);
    endtask

    task automatic test_pulse();
        probes_in = {20'hABCDE, 20'h12345};
        wr(0, 16'h0002);
        idle(1);
        rd(3); checks++; if (data_o !== 16'h2345) begin errors++; $display("FAIL pulse_off3: got %h want 2345", data_o); end
        rd(4); checks++; if (data_o !== 16'h0001) begin errors++; $display("FAIL pulse_off4: got %h want 0001", data_o); end
        rd(5); checks++; if (data_o !== 16'hBCDE) begin errors++; $display("FAIL pulse_off5: got %h want bcde", data_o); end
        rd(6); checks++; if (data_o !== 16'h000A) begin errors++; $display("FAIL pulse_off6: got %h want 000a", data_o); end
        rd(1); checks++; if (data_o !== 16'h0001) begin errors++; $display("FAIL pulse_capcnt: got %h want 0001", data_o); end
        rd(0); checks++; if (data_o !== 16'h0000) begin errors++; $display("FAIL pulse_ctrl: got %h want 0000", data_o); end
        // A pulse captures once only: later probe changes stay invisible.
        probes_in = {20'h55555, 20'h6789A};
        idle(2);
        rd(3); checks++; if (data_o !== 16'h2345) begin errors++; $display("FAIL pulse_once: got %h want 2345", data_o); end
    endtask

    task automatic test_strobe();
        logic [15:0] cnt0;
        logic [15:0] want;
        int k;
        cnt0 = m_cnt;
        wr(0, 16'h0001);
        for (int c = 0; c < 10; c++) begin
            probes_in = PW'({$urandom(), $urandom()});
            idle(1);
        end
        wr(0, 16'h0000);
        rd(1);
        want = cnt0 + 16'd11;
        checks++; if (data_o !== want) begin errors++; $display("FAIL strobe_capcnt: got %h want %h", data_o, want); end
        for (int off = 3; off < OUT_START; off++) begin
            want = model_rd(off);
            rd(off);
            checks++; if (data_o !== want) begin errors++; $display("FAIL strobe_inbuf%0d: got %h want %h", off, data_o, want); end
        end
        // Run the counter up to 0xFFFF, then one more capture must wrap it.
        k = 65534 - int'(m_cnt);
        wr(0, 16'h0001);
        idle(k);
        wr(0, 16'h0000);
        rd(1); checks++; if (data_o !== 16'hFFFF) begin errors++; $display("FAIL capcnt_max: got %h want ffff", data_o); end
        wr(0, 16'h0002);
        idle(1);
        rd(1); checks++; if (data_o !== 16'h0000) begin errors++; $display("FAIL capcnt_wrap: got %h want 0000", data_o); end
    endtask

    task automatic test_outputs();
        wr(OUT_START, 16'h01FF);
        checks++; if (probes_out !== 16'h0000) begin errors++; $display("FAIL out_before_cap: got %h want 0000", probes_out); end
        rd(OUT_START); checks++; if (data_o !== 16'h00FF) begin errors++; $display("FAIL out0_readback: got %h want 00ff", data_o); end
        checks++; if (probes_out !== 16'h0000) begin errors++; $display("FAIL out_still_zero: got %h want 0000", probes_out); end
        wr(0, 16'h0002);
        idle(1);
        checks++; if (probes_out[7:0] !== 8'hFF) begin errors++; $display("FAIL out0_after_pulse: got %h want ff", probes_out[7:0]); end
        // Output write on the same edge as a capture: old value goes out.
        wr(0, 16'h0002);
        wr(OUT_START + 1, 16'h005A);
        checks++; if (probes_out !== 16'h00FF) begin errors++; $display("FAIL out1_same_edge: got %h want 00ff", probes_out); end
        wr(0, 16'h0002);
        idle(1);
        checks++; if (probes_out !== 16'h5AFF) begin errors++; $display("FAIL out1_next_cap: got %h want 5aff", probes_out); end
        rd(OUT_START + 1); checks++; if (data_o !== 16'h005A) begin errors++; $display("FAIL out1_readback: got %h want 005a", data_o); end
    endtask

    task automatic test_change_flags();
        logic [15:0] flag1;
`ifdef PROBE_CHANGE_FLAGS_EN
        flag1 = 16'h0002;
`else
        flag1 = 16'h0000;
`endif
        wr(0, 16'h0002);
        idle(1);
        wr(2, 16'h0003);
        rd(2); checks++; if (data_o !== 16'h0000) begin errors++; $display("FAIL chg_cleared: got %h want 0000", data_o); end
        probes_in[IW] = ~probes_in[IW];
        wr(0, 16'h0002);
        idle(1);
        rd(2); checks++; if (data_o !== flag1) begin errors++; $display("FAIL chg_ch1_set: got %h want %h", data_o, flag1); end
        // W1C on the same edge as a capture that changes channel 1 again: set wins.
        wr(0, 16'h0002);
        probes_in[IW + 3] = ~probes_in[IW + 3];
        wr(2, 16'h0002);
        rd(2); checks++; if (data_o !== flag1) begin errors++; $display("FAIL chg_set_wins: got %h want %h", data_o, flag1); end
        wr(2, 16'h0002);
        rd(2); checks++; if (data_o !== 16'h0000) begin errors++; $display("FAIL chg_w1c: got %h want 0000", data_o); end
    endtask

    task automatic test_passthrough();
        logic [15:0] cnt0;
        logic [15:0] d;
        logic [15:0] want;
        cnt0 = m_cnt;
        d = 16'($urandom());
        drive(1'b1, 1'b0, BASE + 16'd100, d);
        checks++; if (data_o !== d) begin errors++; $display("FAIL oor_read_data: got %h want %h", data_o, d); end
        checks++; if (addr_o !== BASE + 16'd100) begin errors++; $display("FAIL oor_read_addr: got %h want %h", addr_o, BASE + 16'd100); end
        checks++; if (valid_o !== 1'b1 || rw_o !== 1'b0) begin errors++; $display("FAIL oor_read_ctl: got %b%b want 10", valid_o, rw_o); end
        d = 16'($urandom());
        drive(1'b1, 1'b0, BASE - 16'd1, d);
        checks++; if (data_o !== d) begin errors++; $display("FAIL below_base_data: got %h want %h", data_o, d); end
        d = 16'($urandom());
        wr(1, d);
        checks++; if (data_o !== d) begin errors++; $display("FAIL ro_write_data: got %h want %h", data_o, d); end
        checks++; if (rw_o !== 1'b1 || valid_o !== 1'b1) begin errors++; $display("FAIL ro_write_ctl: got %b%b want 11", valid_o, rw_o); end
        want = model_rd(3);
        wr(3, 16'($urandom()));
        rd(3); checks++; if (data_o !== want) begin errors++; $display("FAIL in_region_write: got %h want %h", data_o, want); end
        rd(1); checks++; if (data_o !== cnt0) begin errors++; $display("FAIL capcnt_unchanged: got %h want %h", data_o, cnt0); end
    endtask

    task automatic test_back_to_back();
        int op;
        int off;
        int ch;
        logic [15:0] d;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                ch = $urandom_range(0, NI - 1);
                probes_in[ch*IW +: IW] = probes_in[ch*IW +: IW] ^ IW'($urandom());
            end
            op = $urandom_range(0, 5);
            off = $urandom_range(0, SPAN - 1);
            d = 16'($urandom());
            case (op)
                0, 1, 2: drive(1'b1, 1'b0, 16'(int'(BASE) + off), d);
                3:       drive(1'b1, 1'b1, 16'(int'(BASE) + off), d);
                4:       drive(1'b1, 1'($urandom()), 16'(int'(BASE) + SPAN + $urandom_range(0, 200)), d);
                default: drive(1'b0, 1'($urandom()), 16'(int'(BASE) + off), d);
            endcase
            checks++; if (data_o !== exp_data) begin errors++; $display("FAIL rand_data c%0d: got %h want %h", c, data_o, exp_data); end
            checks++; if (addr_o !== exp_addr || rw_o !== exp_rw || valid_o !== exp_valid) begin
                errors++; $display("FAIL rand_bus c%0d: got %h/%b/%b want %h/%b/%b", c, addr_o, rw_o, valid_o, exp_addr, exp_rw, exp_valid);
            end
            checks++; if (probes_out !== model_pout()) begin errors++; $display("FAIL rand_probes_out c%0d: got %h want %h", c, probes_out, model_pout()); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_pulse();
        test_strobe();
        test_outputs();
        test_change_flags();
        test_passthrough();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
